logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the ALU logic unit. It executes bitwise operations on WIDTH-bit operands with a valid/ready handshake, a configurable pipeline depth and an accumulate mode that chains results through an internal register. It sits in the ALU datapath beside the arithmetic and shift units and can be stalled by downstream backpressure.

---
 rtl/logic_unit_pipe.sv | 93 +++++++++
 tb/tb_logic_unit_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready backpressure and an accumulate mode
// that chains results through an internal register updated at accept time.
module logic_unit_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             rest,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] logic_out,
  output logic             logic_flag,
  output logic             logic_zero,
  input  logic             out_ready
);

  logic [STAGES-1:0][WIDTH-1:0] r_data;
  logic [STAGES-1:0]            r_zero;
  logic [STAGES-1:0]            r_vld;
  logic [WIDTH-1:0]             r_acc;
  logic [STAGES:0]              w_rdy;
  logic [WIDTH-1:0]             w_y;
  logic [WIDTH-1:0]             w_res;
  logic                         w_acc_en;

  assign w_y = ALU_FUN[3] ? r_acc : B;

  always_comb begin
    w_res = '0;
    case (ALU_FUN[2:0])
      3'b000:  w_res = A & w_y;
      3'b001:  w_res = A | w_y;
      3'b010:  w_res = ~(A & w_y);
      3'b011:  w_res = ~(A | w_y);
      3'b100:  w_res = A ^ w_y;
      3'b101:  w_res = ~(A ^ w_y);
      3'b110:  w_res = A & ~w_y;
      default: w_res = ~A;
    endcase
  end

  // Ready ripples back from the output so full pipes still advance when the head drains.
  always_comb begin
    w_rdy = '0;
    w_rdy[STAGES] = out_ready;
    for (int k = STAGES-1; k >= 0; k--)
      w_rdy[k] = !r_vld[k] || w_rdy[k+1];
  end

  assign in_ready = w_rdy[0];
  assign w_acc_en = in_valid && w_rdy[0] && ALU_FUN[3];

  always_ff @(posedge clock or negedge rest) begin
    if (!rest) begin
      r_data <= '0;
      r_zero <= '0;
      r_vld  <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_vld[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_res;
          r_zero[0] <= (w_res == '0);
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_zero[k] <= r_zero[k-1];
          end
        end
      end
    end
  end

  // Clear wins over an accumulate update; the op in that cycle already used the old value.
  always_ff @(posedge clock or negedge rest) begin
    if (!rest)         r_acc <= '0;
    else if (acc_clr)  r_acc <= '0;
    else if (w_acc_en) r_acc <= w_res;
  end

  assign logic_out  = r_data[STAGES-1];
  assign logic_flag = r_vld[STAGES-1];
  assign logic_zero = r_zero[STAGES-1] && r_vld[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=16, STAGES=2) with hand-computed results.
module tb_logic_unit_pipe;
  localparam int W = 16;
  localparam int S = 2;

  logic         clock = 1'b0;
  logic         rest;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_FUN;
  logic         acc_clr;
  logic [W-1:0] logic_out;
  logic         logic_flag;
  logic         logic_zero;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clock(clock), .rest(rest), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .acc_clr(acc_clr),
    .logic_out(logic_out), .logic_flag(logic_flag), .logic_zero(logic_zero),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f);
    in_valid = v; A = a; B = b; ALU_FUN = f;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] d, input logic z);
    chk({tag, "_flag"}, {31'd0, logic_flag}, 32'd1);
    chk({tag, "_out"},  {16'd0, logic_out},  {16'd0, d});
    chk({tag, "_zero"}, {31'd0, logic_zero}, {31'd0, z});
  endtask

  initial begin
    rest = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALU_FUN = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_flag", {31'd0, logic_flag}, 32'd0);
    chk("rst_out",  {16'd0, logic_out},  32'd0);
    chk("rst_zero", {31'd0, logic_zero}, 32'd0);
    rest = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Basic latency: accept, visible one cycle later for one cycle.
    drive(1, 16'hF0F0, 16'hFF00, 4'b0000);
    tick(); drive(0, 0, 0, 0);
    chk("lat_early_flag", {31'd0, logic_flag}, 32'd0);
    tick(); chk_out("and", 16'hF000, 1'b0);
    tick(); chk("lat_drop_flag", {31'd0, logic_flag}, 32'd0);

    // Function sweep, back-to-back at full throughput.
    drive(1, 16'h1234, 16'h1234, 4'b0100); tick();
    drive(1, 16'h1234, 16'h1234, 4'b0101); tick(); chk_out("xor", 16'h0000, 1'b1);
    drive(1, 16'h1234, 16'h1234, 4'b0111); tick(); chk_out("xnor", 16'hFFFF, 1'b0);
    drive(1, 16'h1234, 16'h1234, 4'b0110); tick(); chk_out("nota", 16'hEDCB, 1'b0);
    drive(1, 16'h1234, 16'h0F0F, 4'b0011); tick(); chk_out("andn", 16'h0000, 1'b1);
    drive(0, 0, 0, 0);                     tick(); chk_out("nor", 16'hE0C0, 1'b0);
    tick();

    // Accumulate chaining (acc=0 from reset); B must be ignored.
    drive(1, 16'h000F, 16'hAAAA, 4'b1001); tick();
    drive(1, 16'h00F0, 16'h5555, 4'b1001); tick(); chk_out("acc1", 16'h000F, 1'b0);
    drive(1, 16'h00FF, 16'h1111, 4'b1100); tick(); chk_out("acc2", 16'h00FF, 1'b0);
    drive(0, 0, 0, 0);                     tick(); chk_out("acc3", 16'h0000, 1'b1);
    tick();

    // Backpressure: two ops fill the pipe, third waits for the head transfer.
    out_ready = 1'b0;
    drive(1, 16'd1, 16'd0, 4'b0001); #1;
    chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1, 16'd2, 16'd0, 4'b0001); #1;
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    drive(1, 16'd3, 16'd0, 4'b0001); #1;
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    tick();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    chk_out("bp_head", 16'd1, 1'b0);
    out_ready = 1'b1; #1;
    chk("bp_comb_rdy", {31'd0, in_ready}, 32'd1);
    tick(); drive(0, 0, 0, 0);
    chk_out("bp_o2", 16'd2, 1'b0);
    tick(); chk_out("bp_o3", 16'd3, 1'b0);
    tick(); chk("bp_empty", {31'd0, logic_flag}, 32'd0);

    // acc_clr collides with an accumulate accept (acc currently 0).
    drive(1, 16'h00FF, 16'h0, 4'b1001); tick();
    drive(1, 16'h0100, 16'h0, 4'b1001); acc_clr = 1'b1; tick();
    chk_out("clr_pre", 16'h00FF, 1'b0);
    drive(1, 16'h0001, 16'h0, 4'b1001); acc_clr = 1'b0; tick();
    chk_out("clr_col", 16'h01FF, 1'b0);
    drive(0, 0, 0, 0); tick();
    chk_out("clr_after", 16'h0001, 1'b0);
    tick();

    // Reset mid-flight with a nonzero accumulator.
    out_ready = 1'b0;
    drive(1, 16'h00AA, 16'h0, 4'b1001); tick();
    drive(1, 16'h0F00, 16'h0, 4'b1001); tick();
    drive(0, 0, 0, 0);
    chk("mr_pre_flag", {31'd0, logic_flag}, 32'd1);
    #2 rest = 1'b0; #1;
    chk("mr_flag", {31'd0, logic_flag}, 32'd0);
    chk("mr_out",  {16'd0, logic_out},  32'd0);
    tick();
    rest = 1'b1; out_ready = 1'b1;
    tick(); chk("mr_gone1", {31'd0, logic_flag}, 32'd0);
    tick(); chk("mr_gone2", {31'd0, logic_flag}, 32'd0);
    drive(1, 16'hF0F0, 16'hFF00, 4'b0000); tick();
    drive(1, 16'h0005, 16'h0, 4'b1001); tick();
    chk_out("mr_first", 16'hF000, 1'b0);
    drive(0, 0, 0, 0); tick();
    chk_out("mr_acc0", 16'h0005, 1'b0);
    tick(); chk("mr_end", {31'd0, logic_flag}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
